// File: rtl/ro_freq_counter_pkg.sv
// Shared definitions for the ring-oscillator temperature sensor measurement path:
// FSM encodings, default timing parameters and oscillator select codes.
package ro_freq_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_DONE   = 2'd3
  } ro_state_e;

  localparam int unsigned DEF_COUNT_W       = 16;
  localparam int unsigned DEF_GATE_CYCLES   = 1000;
  localparam int unsigned DEF_SETTLE_CYCLES = 8;
  localparam int unsigned DEF_SYNC_STAGES   = 2;

  localparam logic RO_INV2  = 1'b0;
  localparam logic RO_NAND4 = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_freq_counter_edge_sync.sv
// Brings the free-running ring output into clk through a flop chain and flags
// each rising edge seen on the last stage for exactly one clk cycle.
module ro_freq_counter_edge_sync
  import ro_freq_counter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ro_async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // History is reloaded every cycle, so an edge older than one cycle never re-fires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Enables one ring oscillator, lets it settle, then counts its synchronised rising
// edges over a fixed clk window and holds the saturating count as the result.
module ro_freq_counter
  import ro_freq_counter_pkg::*;
#(
  parameter int unsigned COUNT_W       = DEF_COUNT_W,
  parameter int unsigned GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sel,
  input  logic               ro_in_inv2,
  input  logic               ro_in_nand4,
  output logic               ro_en_inv2,
  output logic               ro_en_nand4,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] result,
  output logic               overflow,
  output ro_state_e          dbg_state_o
);

  localparam int unsigned WIN_MAX = max_u(max_u(GATE_CYCLES, SETTLE_CYCLES), 2);
  localparam int unsigned WIN_W   = $clog2(WIN_MAX);
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  ro_state_e          state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               sel_q, sel_d;
  logic [COUNT_W-1:0] result_q, result_d;
  logic               overflow_q, overflow_d;
  logic               ro_mux;
  logic               rise;

  // Only the latched selection reaches the synchroniser; one chain serves both rings.
  assign ro_mux = (sel_q == RO_NAND4) ? ro_in_nand4 : ro_in_inv2;

  ro_freq_counter_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ro_async_i(ro_mux),
    .rise_o    (rise)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      win_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      sel_q      <= RO_INV2;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      sel_q      <= sel_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  // start is a one-cycle request honoured only in IDLE; there is no ready, and a
  // start seen in any other state is dropped. done marks result/overflow valid.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    sel_d      = sel_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d   = sel;
          win_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = '0;
        ovf_d = 1'b0;
        if (win_q == WIN_W'(SETTLE_CYCLES - 1)) begin
          win_d   = '0;
          state_d = ST_GATE;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      ST_GATE: begin
        if (rise) begin
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + COUNT_W'(1);
        end
        // Capture on the way into DONE so the result is already valid while done is high.
        if (win_q == WIN_W'(GATE_CYCLES - 1)) begin
          result_d   = cnt_d;
          overflow_d = ovf_d;
          state_d    = ST_DONE;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy        = (state_q == ST_SETTLE) || (state_q == ST_GATE);
  assign done        = (state_q == ST_DONE);
  assign ro_en_inv2  = busy && (sel_q == RO_INV2);
  assign ro_en_nand4 = busy && (sel_q == RO_NAND4);
  assign result      = result_q;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: a 16-bit and a 6-bit instance share all inputs and are
// checked every cycle against an edge-counting model of the ring waveforms.
module tb_ro_freq_counter;
  import ro_freq_counter_pkg::*;

  localparam int G        = 1000;
  localparam int S        = 8;
  localparam int L        = 2;
  localparam int CLK_HALF = 50;
  localparam int WIN_T    = 2 * CLK_HALF * G;
  localparam int MAX_A    = 65535;
  localparam int MAX_B    = 63;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic ro_inv2 = 1'b0;
  logic ro_nand4 = 1'b0;

  logic        en_inv2_a, en_nand4_a, busy_a, done_a, ovf_a;
  logic [15:0] res_a;
  ro_state_e   st_a;
  logic        en_inv2_b, en_nand4_b, busy_b, done_b, ovf_b;
  logic [5:0]  res_b;
  ro_state_e   st_b;

  ro_freq_counter u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel),
    .ro_in_inv2(ro_inv2), .ro_in_nand4(ro_nand4),
    .ro_en_inv2(en_inv2_a), .ro_en_nand4(en_nand4_a),
    .busy(busy_a), .done(done_a), .result(res_a), .overflow(ovf_a),
    .dbg_state_o(st_a)
  );

  ro_freq_counter #(.COUNT_W(6)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel),
    .ro_in_inv2(ro_inv2), .ro_in_nand4(ro_nand4),
    .ro_en_inv2(en_inv2_b), .ro_en_nand4(en_nand4_b),
    .busy(busy_b), .done(done_b), .result(res_b), .overflow(ovf_b),
    .dbg_state_o(st_b)
  );

  // ---------------- clock / reset / ring stimulus ----------------
  initial forever #CLK_HALF clk = ~clk;

  int half_inv2 = 500;
  int half_nand4 = 1250;
  bit run_inv2 = 1'b0;
  bit run_nand4 = 1'b0;

  // Ring toggles stay 17 time units off a 50-unit grid, so they never meet a clk edge.
  initial begin
    #17;
    forever begin
      #(half_inv2);
      ro_inv2 = run_inv2 ? ~ro_inv2 : 1'b0;
    end
  end

  initial begin
    #17;
    forever begin
      #(half_nand4);
      ro_nand4 = run_nand4 ? ~ro_nand4 : 1'b0;
    end
  end

  // ---------------- reference model ----------------
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  bit s_inv2 [0:65535];
  bit s_nand4 [0:65535];
  bit m_active = 1'b0;
  int m_start = 0;
  bit m_sel = 1'b0;
  int m_res_a = 0;
  int m_res_b = 0;
  bit m_ovf_a = 1'b0;
  bit m_ovf_b = 1'b0;

  // Count = rising transitions of the selected ring as sampled by clk, seen L cycles
  // late through the synchroniser, over the G gate cycles that follow S settle cycles.
  task automatic model_result();
    int n = 0;
    int m;
    bit b1, b0;
    for (int k = S + 1; k <= S + G; k++) begin
      m  = m_start + k - 1;
      b1 = m_sel ? s_nand4[16'(m - L + 1)] : s_inv2[16'(m - L + 1)];
      b0 = m_sel ? s_nand4[16'(m - L)]     : s_inv2[16'(m - L)];
      if (b1 && !b0) n++;
    end
    m_res_a = (n > MAX_A) ? MAX_A : n;
    m_ovf_a = (n > MAX_A);
    m_res_b = (n > MAX_B) ? MAX_B : n;
    m_ovf_b = (n > MAX_B);
  endtask

  // Age 1 is the first cycle after the accepting edge; done is expected at age S+G+1.
  always @(posedge clk) begin
    int a;
    s_inv2[16'(cyc)]  = ro_inv2;
    s_nand4[16'(cyc)] = ro_nand4;
    if (!rst_n) begin
      m_active = 1'b0;
      m_res_a  = 0;
      m_res_b  = 0;
      m_ovf_a  = 1'b0;
      m_ovf_b  = 1'b0;
    end else if (m_active) begin
      a = cyc - m_start + 1;
      if (a == S + G + 1) model_result();
      else if (a == S + G + 2) m_active = 1'b0;
    end else if (start) begin
      m_active = 1'b1;
      m_start  = cyc;
      m_sel    = sel;
    end
    cyc++;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic check_ideal(input string name, input int act, input int half);
    int p;
    p = 2 * half;
    check_range(name, act, WIN_T / p - 1, (WIN_T + p - 1) / p + 1);
  endtask

  always @(negedge clk) begin
    int a;
    bit eb, ed;
    if (cyc > 0) begin
      a  = cyc - m_start;
      eb = m_active && a >= 1 && a <= S + G;
      ed = m_active && a == S + G + 1;
      if (done_a === 1'b1) n_done++;
      check("busy_a", 32'(busy_a), 32'(eb));
      check("done_a", 32'(done_a), 32'(ed));
      check("en_inv2_a", 32'(en_inv2_a), 32'(eb && !m_sel));
      check("en_nand4_a", 32'(en_nand4_a), 32'(eb && m_sel));
      check("result_a", 32'(res_a), 32'(m_res_a));
      check("overflow_a", 32'(ovf_a), 32'(m_ovf_a));
      check("busy_b", 32'(busy_b), 32'(eb));
      check("done_b", 32'(done_b), 32'(ed));
      check("en_inv2_b", 32'(en_inv2_b), 32'(eb && !m_sel));
      check("en_nand4_b", 32'(en_nand4_b), 32'(eb && m_sel));
      check("result_b", 32'(res_b), 32'(m_res_b));
      check("overflow_b", 32'(ovf_b), 32'(m_ovf_b));
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic set_ro(input int h_inv2, input int h_nand4, input bit r_inv2, input bit r_nand4);
    half_inv2  = h_inv2;
    half_nand4 = h_nand4;
    run_inv2   = r_inv2;
    run_nand4  = r_nand4;
    repeat (60) @(negedge clk);
  endtask

  task automatic pulse_start(input bit s, output int t_start);
    @(negedge clk);
    sel     = s;
    start   = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
    sel   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int budget, output int done_cyc);
    int k = 0;
    while (done_a !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 32'(done_a), 32'd1);
    done_cyc = cyc;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t0, t1, td, td2, d0, h, hn;
    bit s, ri, rn;

    repeat (4) @(negedge clk);
    check("rst_result", 32'(res_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_en", 32'(en_inv2_a | en_nand4_a), 32'd0);
    rst_n = 1'b1;

    // 1 us inv2 ring, inv2 selected
    set_ro(500, 1250, 1'b1, 1'b0);
    pulse_start(1'b0, t0);
    check("t1_en_inv2", 32'(en_inv2_a), 32'd1);
    check("t1_en_nand4", 32'(en_nand4_a), 32'd0);
    wait_done(1100, td);
    check("t1_latency", 32'(td - t0), 32'd1009);
    check_range("t1_result", int'(res_a), 99, 101);
    check_range("t1_model", m_res_a, 99, 101);
    check("t1_ovf", 32'(ovf_a), 32'd0);
    check("t1_sat_b", 32'(res_b), 32'd63);
    check("t1_ovf_b", 32'(ovf_b), 32'd1);

    // nand4 selected at 2.5 us while inv2 keeps toggling
    set_ro(500, 1250, 1'b1, 1'b1);
    pulse_start(1'b1, t0);
    wait_done(1100, td);
    check_range("t2_result", int'(res_a), 39, 41);
    check_range("t2_result_b", int'(res_b), 39, 41);
    check("t2_ovf_b", 32'(ovf_b), 32'd0);

    // 400 ns ring saturates the 6-bit instance, then a slow ring clears overflow
    set_ro(200, 1250, 1'b1, 1'b0);
    pulse_start(1'b0, t0);
    wait_done(1100, td);
    check_ideal("t3_result", int'(res_a), 200);
    check("t3_sat_b", 32'(res_b), 32'd63);
    check("t3_ovf_b", 32'(ovf_b), 32'd1);
    set_ro(2500, 1250, 1'b1, 1'b0);
    pulse_start(1'b0, t0);
    wait_done(1100, td);
    check_range("t3_slow_b", int'(res_b), 19, 21);
    check("t3_clear_ovf_b", 32'(ovf_b), 32'd0);

    // second start in the middle of the gate window is dropped
    set_ro(500, 1250, 1'b1, 1'b0);
    d0 = n_done;
    pulse_start(1'b0, t0);
    repeat (S + 500) @(negedge clk);
    sel   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1100, td);
    repeat (20) @(negedge clk);
    check("t4_done_count", 32'(n_done - d0), 32'd1);
    check_range("t4_result", int'(res_a), 99, 101);

    // reset during the gate window
    pulse_start(1'b0, t0);
    repeat (S + 300) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_en", 32'(en_inv2_a | en_nand4_a), 32'd0);
    check("t5_busy", 32'(busy_a), 32'd0);
    check("t5_result", 32'(res_a), 32'd0);
    check("t5_ovf_b", 32'(ovf_b), 32'd0);
    d0 = n_done;
    repeat (1020) @(negedge clk);
    check("t5_no_done", 32'(n_done - d0), 32'd0);
    pulse_start(1'b0, t0);
    wait_done(1100, td);
    check_range("t5_rerun", int'(res_a), 99, 101);

    // quiet ring, back-to-back measurements
    set_ro(500, 1250, 1'b0, 1'b0);
    pulse_start(1'b0, t0);
    wait_done(1100, td);
    check("t6_result", 32'(res_a), 32'd0);
    check("t6_ovf", 32'(ovf_a), 32'd0);
    check("t6_result_b", 32'(res_b), 32'd0);
    pulse_start(1'b1, t1);
    wait_done(1100, td2);
    check("t6_spacing", 32'(td2 - td), 32'd1010);
    check("t6_result2", 32'(res_a), 32'd0);

    // randomized rings, selection and stray starts
    for (int i = 0; i < 8; i++) begin
      h  = 50 * $urandom_range(3, 40);
      hn = 50 * $urandom_range(3, 40);
      ri = 1'($urandom_range(0, 3) != 0);
      rn = 1'($urandom_range(0, 3) != 0);
      s  = 1'($urandom_range(0, 1));
      set_ro(h, hn, ri, rn);
      pulse_start(s, t0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 900)) @(negedge clk);
        sel   = ~sel;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done(1100, td);
      if (s && rn) check_ideal("rnd_nand4", int'(res_a), hn);
      else if (!s && ri) check_ideal("rnd_inv2", int'(res_a), h);
      else check("rnd_quiet", 32'(res_a), 32'd0);
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
